// File: rtl/pc_pkg.sv
// pc_pkg -- shared types and constants for the program-counter unit.
//   pcsrc_e    : next-PC source select encoding driven by the control unit
//   pc_state_e : PC unit FSM states
//   PC_INC     : sequential instruction stride in bytes
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,  // pc + 4
    PC_BRANCH = 2'b01,  // pc + immext
    PC_JALR   = 2'b10,  // (rs1_data + immext) & ~1
    PC_RSVD   = 2'b11   // treated as pc + 4
  } pcsrc_e;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    FAULT = 2'b10
  } pc_state_e;

  localparam int PC_INC = 4;

endpackage

// File: rtl/pc_ras.sv
// pc_ras -- circular return-address stack.
//   clk, rst    : clock, async active-high reset (clears pointer and count)
//   push, pop   : qualified stack operations (caller gates with RUN/!stall)
//   push_data   : return address to store on push
//   top         : top-of-stack entry, 0 when empty
//   empty       : no valid entries
// Push when full overwrites the oldest entry (count saturates at RAS_DEPTH);
// push+pop together replace the top entry; pop on empty is ignored.
module pc_ras #(
  parameter int RAS_DEPTH     = 4,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ADDRESS_WIDTH-1:0] push_data,
  output logic [ADDRESS_WIDTH-1:0] top,
  output logic                     empty
);

  localparam int PW = $clog2(RAS_DEPTH);

  logic [ADDRESS_WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]            ptr;
  logic [PW:0]              count;
  logic                     wr_en;
  logic [PW-1:0]            wr_idx;
  logic                     replace;

  assign empty   = (count == '0);
  assign top     = empty ? '0 : mem[ptr];
  assign replace = push && pop && !empty;
  assign wr_en   = push;
  assign wr_idx  = replace ? ptr : ptr + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (replace) begin
      ptr   <= ptr;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (count != (PW+1)'(RAS_DEPTH)) count <= count + (PW+1)'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - PW'(1);
      count <= count - (PW+1)'(1);
    end
  end

  // Entries need no reset: top is masked to 0 while the stack is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit -- registered program counter with next-PC select, stall,
// misaligned-target trap and optional return-address stack.
//   Optional feature macro: PC_RAS_EN (enables the pc_ras stack).
// Ports:
//   clk, rst       : clock, async active-high reset
//   stall          : hold pc, RAS and state
//   pcsrc          : next-PC source (see pc_pkg::pcsrc_e)
//   immext         : sign-extended immediate
//   rs1_data       : JALR base register
//   ras_push/pop   : call / return hints
//   fault_clear    : leave FAULT and restart at RESET_VECTOR
//   pc, pc_plus4   : current PC (registered) and pc+4
//   pc_valid       : pc fetchable (RUN)
//   fault          : misaligned target captured (FAULT)
//   fault_addr     : offending target while fault=1
//   ras_top        : predicted return address, 0 when empty
//   ras_empty      : stack holds no entries
module pc_unit
  import pc_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter int                     DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                     RAS_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic [1:0]               pcsrc,
  input  logic [DATA_WIDTH-1:0]    immext,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic                     ras_push,
  input  logic                     ras_pop,
  input  logic                     fault_clear,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4,
  output logic                     pc_valid,
  output logic                     fault,
  output logic [ADDRESS_WIDTH-1:0] fault_addr,
  output logic [ADDRESS_WIDTH-1:0] ras_top,
  output logic                     ras_empty
);

  pc_state_e                state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] fault_addr_q, fault_addr_d;
  logic [ADDRESS_WIDTH-1:0] imm_a, rs1_a, target;
  logic                     misaligned;
  logic                     advance;

  // Operands are resized to the address width so all sums wrap modulo 2^AW.
  assign imm_a    = ADDRESS_WIDTH'(immext);
  assign rs1_a    = ADDRESS_WIDTH'(rs1_data);
  assign pc_plus4 = pc_q + ADDRESS_WIDTH'(PC_INC);

  always_comb begin
    target = pc_plus4;
    case (pcsrc_e'(pcsrc))
      PC_BRANCH: target = pc_q + imm_a;
      PC_JALR:   target = (rs1_a + imm_a) & ~ADDRESS_WIDTH'(1);
      default:   target = pc_plus4;
    endcase
  end

  assign misaligned = |target[1:0];
  // A cycle that actually moves the PC; the RAS only operates on these.
  assign advance    = (state_q == RUN) && !stall && !misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_addr_d = fault_addr_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        pc_d    = RESET_VECTOR;
      end
      RUN: begin
        if (!stall) begin
          if (misaligned) begin
            state_d      = FAULT;
            fault_addr_d = target;
          end else begin
            pc_d = target;
          end
        end
      end
      FAULT: begin
        if (fault_clear) begin
          state_d      = BOOT;
          pc_d         = RESET_VECTOR;
          fault_addr_d = '0;
        end
      end
      default: begin
        state_d = BOOT;
        pc_d    = RESET_VECTOR;
      end
    endcase
  end

  assign pc         = pc_q;
  assign pc_valid   = (state_q == RUN);
  assign fault      = (state_q == FAULT);
  assign fault_addr = fault_addr_q;

`ifdef PC_RAS_EN
  pc_ras #(
    .RAS_DEPTH     (RAS_DEPTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (advance && ras_push),
    .pop       (advance && ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  logic ras_unused;
  assign ras_unused = ras_push ^ ras_pop ^ advance;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
`endif

endmodule
